// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   DEF_WIDTH  default operand width
//   state_e    FSM state encoding (also decoded by control_unit)
//   cnt_width  step-counter width for a given operand width
package mult_div_unit_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // One extra bit so the counter can hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between control_unit and mult_div_unit.
//   MULT_on/DIV_on  start strobes (master -> unit)
//   A_in/B_in       operands      (master -> unit)
//   Hi_out/Lo_out   result halves (unit -> master)
//   busy/done       progress      (unit -> master)
//   div_zero        divide-by-zero pulse, coincident with done
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             MULT_on;
  logic             DIV_on;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output MULT_on, DIV_on, A_in, B_in,
    input  Hi_out, Lo_out, busy, done, div_zero
  );

  modport slave (
    input  MULT_on, DIV_on, A_in, B_in,
    output Hi_out, Lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes.
//   rem_in   partial remainder (always < divisor, so WIDTH bits suffice)
//   in_bit   next dividend bit shifted in from the top
//   divisor  divisor magnitude, WIDTH+1 bits so |0x80000000| is representable
//   rem_out  next partial remainder
//   q_bit    quotient bit produced by this step
module mult_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             in_bit,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  assign shifted = {rem_in, in_bit};
  assign q_bit   = (shifted >= divisor);
  // Either result is below the divisor, so the top bit is always zero.
  assign rem_out = WIDTH'(q_bit ? (shifted - divisor) : shifted);
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    slave side of mult_div_unit_if (strobes, operands, {Hi,Lo}, busy,
//          done, div_zero)
// MULT: radix-2 Booth, one step per cycle, done WIDTH+1 cycles after the start.
// DIV : restoring division on magnitudes, then a sign fix-up cycle, done
//       WIDTH+2 cycles after the start. Divide by zero finishes in one cycle with
//       div_zero set and the previous result kept.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);
  localparam int                 CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] count;

  // q is shared: Booth multiplier register in MULT, dividend/quotient in DIV.
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   acc;    // one guard bit so min*min cannot overflow
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   dvsr;
  logic             sign_a, sign_b;

  // Booth step on {acc,q,q_1}
  logic [WIDTH:0]   booth_sum, acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_1_nx;

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    // Arithmetic right shift of the whole chain.
    {acc_nx, q_nx, q_1_nx} = {booth_sum[WIDTH], booth_sum, q};
  end

  // Operand magnitudes for DIV.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_ext, b_mag;

  assign a_mag = bus.A_in[WIDTH-1] ? -bus.A_in : bus.A_in;
  assign b_ext = {bus.B_in[WIDTH-1], bus.B_in};
  assign b_mag = b_ext[WIDTH] ? -b_ext : b_ext;

  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .in_bit  (q[WIDTH-1]),
    .divisor (dvsr),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign quo_fix = (sign_a ^ sign_b) ? -q : q;
  assign rem_fix = sign_a ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      q            <= '0;
      q_1          <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      rem          <= '0;
      dvsr         <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      bus.Hi_out   <= '0;
      bus.Lo_out   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      // done/div_zero are set only on entry to DONE, which lasts one cycle.
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MULT_on) begin
            mcand    <= {bus.A_in[WIDTH-1], bus.A_in};
            q        <= bus.B_in;
            q_1      <= 1'b0;
            acc      <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= MULT;
          end else if (bus.DIV_on) begin
            if (bus.B_in == '0) begin
              bus.done     <= 1'b1;
              bus.div_zero <= 1'b1;
              state        <= DONE;
            end else begin
              q        <= a_mag;
              dvsr     <= b_mag;
              rem      <= '0;
              sign_a   <= bus.A_in[WIDTH-1];
              sign_b   <= bus.B_in[WIDTH-1];
              count    <= '0;
              bus.busy <= 1'b1;
              state    <= DIV;
            end
          end
        end
        MULT: begin
          acc   <= acc_nx;
          q     <= q_nx;
          q_1   <= q_1_nx;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            // Last step: register the product straight from the step output.
            bus.Hi_out <= acc_nx[WIDTH-1:0];
            bus.Lo_out <= q_nx;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= DONE;
          end
        end
        DIV: begin
          rem   <= rem_nx;
          q     <= {q[WIDTH-2:0], q_bit};
          count <= count + CNT_W'(1);
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          bus.Hi_out <= rem_fix;
          bus.Lo_out <= quo_fix;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string         name;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          dz;
    int            done_cyc;
    int            busy_cyc;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) busy_run = 0;
    else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        ndone++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_hi"},      bus.Hi_out,       e.hi);
          chk({e.name, "_lo"},      bus.Lo_out,       e.lo);
          chk({e.name, "_dz"},      W'(bus.div_zero), W'(e.dz));
          chk({e.name, "_latency"}, W'(cyc),          W'(e.done_cyc));
          chk({e.name, "_busy"},    W'(busy_run),     W'(e.busy_cyc));
        end
        busy_run = 0;
      end
    end
  end

  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo,
                        input bit dz, input int lat, input int bsy, input bit noise);
    int t;
    int n0;
    bit seen;
    @(negedge clk);
    bus.MULT_on = m;
    bus.DIV_on  = d;
    bus.A_in    = a;
    bus.B_in    = b;
    t  = cyc;
    n0 = ndone;
    sbq.push_back('{name, hi, lo, dz, t + lat, bsy});
    @(negedge clk);
    bus.MULT_on = 1'b0;
    bus.DIV_on  = 1'b0;
    bus.A_in    = $urandom;
    bus.B_in    = $urandom;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(posedge clk);
      if (ndone != n0) seen = 1'b1;
      else begin
        @(negedge clk);
        bus.DIV_on = noise && (cyc == t + 5 || cyc == t + 10);
      end
    end
    bus.DIV_on = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 80 cycles", name);
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.MULT_on = 1'b0;
    bus.DIV_on  = 1'b0;
    bus.A_in    = '0;
    bus.B_in    = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   bus.Hi_out,       '0);
    chk("rst_lo",   bus.Lo_out,       '0);
    chk("rst_busy", W'(bus.busy),     '0);
    chk("rst_done", W'(bus.done),     '0);
    chk("rst_dz",   W'(bus.div_zero), '0);
    reset = 1'b1;

    //      name         M  D  A             B             Hi            Lo            dz lat bsy noise
    run_op("mul_7xm3",   1, 0, 32'd7,        -32'sd3,      32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, 32, 0);
    run_op("mul_minmin", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 33, 32, 0);
    run_op("mul_maxmax", 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 33, 32, 0);
    run_op("mul_m1m1",   1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 33, 32, 0);
    run_op("div_m7_2",   0, 1, -32'sd7,      32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 33, 0);
    run_op("div_100_7",  0, 1, 32'd100,      32'd7,        32'd2,        32'd14,       0, 34, 33, 0);
    run_op("div_7_m2",   0, 1, 32'd7,        -32'sd2,      32'd1,        32'hFFFFFFFD, 0, 34, 33, 0);
    run_op("div_m8_m3",  0, 1, -32'sd8,      -32'sd3,      32'hFFFFFFFE, 32'd2,        0, 34, 33, 0);
    run_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 34, 33, 0);
    run_op("div_5_2",    0, 1, 32'd5,        32'd2,        32'd1,        32'd2,        0, 34, 33, 0);
    run_op("div_5_0",    0, 1, 32'd5,        32'd0,        32'd1,        32'd2,        1,  1,  0, 0);
    run_op("both_3x4",   1, 1, 32'd3,        32'd4,        32'd0,        32'd12,       0, 33, 32, 1);

    // Reset in the middle of a multiply: no result, everything cleared.
    @(negedge clk);
    bus.MULT_on = 1'b1;
    bus.A_in    = 32'd5;
    bus.B_in    = 32'd6;
    t = cyc;
    @(negedge clk);
    bus.MULT_on = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_hi",   bus.Hi_out,       '0);
    chk("midrst_lo",   bus.Lo_out,       '0);
    chk("midrst_busy", W'(bus.busy),     '0);
    chk("midrst_done", W'(bus.done),     '0);
    chk("midrst_dz",   W'(bus.div_zero), '0);
    reset = 1'b1;
    run_op("div_9_3",    0, 1, 32'd9,        32'd3,        32'd0,        32'd3,        0, 34, 33, 0);

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", W'(sbq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
